// File: rtl/cache_defs.sv
// Shared cache definitions: FSM state encoding, default geometry and the
// address-field width helpers used by the instruction cache (and a future
// data cache). A 32-bit byte address splits into tag | index | word | 2'b00.
package cache_defs;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } cache_state_e;

   localparam int DEF_NUMLINES  = 64;
   localparam int DEF_LINEWORDS = 4;

   // Bits selecting a word within a line.
   function automatic int off_bits(input int linewords);
      return $clog2(linewords);
   endfunction

   // Bits selecting a line.
   function automatic int ind_bits(input int numlines);
      return $clog2(numlines);
   endfunction

   // Remaining upper address bits once byte, word and line bits are removed.
   function automatic int tag_bits(input int numlines, input int linewords);
      return 30 - off_bits(linewords) - ind_bits(numlines);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Ports:
//   ph1, reset        clock and synchronous active-high reset (valid bits only)
//   rd_index_i/word_i asynchronous lookup address
//   rd_valid_o/tag_o  valid bit and tag of the addressed line
//   rd_data_o         addressed word of the line
//   wr_en_i, wr_*_i   synchronous single-word write into the data store
//   set_valid_i       mark line wr_index_i valid and store wr_tag_i
//   clr_valid_i       invalidate line clr_index_i
//   flash_clr_i       clear every valid bit
module icache_array
   import cache_defs::*;
#(
   parameter  int NUMLINES  = DEF_NUMLINES,
   parameter  int LINEWORDS = DEF_LINEWORDS,
   localparam int OFFB      = off_bits(LINEWORDS),
   localparam int INDB      = ind_bits(NUMLINES),
   localparam int TAGB      = tag_bits(NUMLINES, LINEWORDS)
) (
   input  logic            ph1,
   input  logic            reset,
   input  logic [INDB-1:0] rd_index_i,
   input  logic [OFFB-1:0] rd_word_i,
   output logic            rd_valid_o,
   output logic [TAGB-1:0] rd_tag_o,
   output logic [31:0]     rd_data_o,
   input  logic            wr_en_i,
   input  logic [INDB-1:0] wr_index_i,
   input  logic [OFFB-1:0] wr_word_i,
   input  logic [31:0]     wr_data_i,
   input  logic [TAGB-1:0] wr_tag_i,
   input  logic            set_valid_i,
   input  logic [INDB-1:0] clr_index_i,
   input  logic            clr_valid_i,
   input  logic            flash_clr_i
);

   logic [NUMLINES-1:0] valid_q;
   logic [TAGB-1:0]     tag_q  [NUMLINES];
   logic [31:0]         data_q [NUMLINES*LINEWORDS];

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[{rd_index_i, wr_word_sel(rd_word_i)}];

   function automatic logic [OFFB-1:0] wr_word_sel(input logic [OFFB-1:0] w);
      return w;
   endfunction

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of process ordering.
   always_ff @(posedge ph1) begin
      if (reset || flash_clr_i) begin
         valid_q <= '0;
      end else begin
         if (clr_valid_i) valid_q[clr_index_i] <= 1'b0;
         if (set_valid_i) valid_q[wr_index_i]  <= 1'b1;
      end
   end

   // NOTE: tag and data stores carry no reset; a line is only observable once
   // its valid bit is set, so clearing them would buy nothing but reset fan-out.
   always_ff @(posedge ph1) begin
      if (set_valid_i) tag_q[wr_index_i] <= wr_tag_i;
      if (wr_en_i)     data_q[{wr_index_i, wr_word_i}] <= wr_data_i;
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache between the fetch port and a
// word-wide memory read port. Hits return combinationally in the cycle pc is
// presented; a miss refills the whole line sequentially from word 0.
// Ports:
//   ph1, reset          clock and synchronous active-high reset
//   pc                  fetch byte address ([1:0] ignored)
//   invalidate          one-cycle pulse clearing all valid bits (aborts a fill)
//   instr, instrack     fetched word and its valid flag
//   memadr, memrequest  refill word address and read request
//   memdata, memack     refill data and its acknowledge
module icache
   import cache_defs::*;
#(
   parameter int NUMLINES  = DEF_NUMLINES,
   parameter int LINEWORDS = DEF_LINEWORDS
) (
   input  logic        ph1,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        invalidate,
   output logic [31:0] instr,
   output logic        instrack,
   output logic [31:0] memadr,
   output logic        memrequest,
   input  logic [31:0] memdata,
   input  logic        memack
);

   localparam int OFFB = off_bits(LINEWORDS);
   localparam int INDB = ind_bits(NUMLINES);
   localparam int TAGB = tag_bits(NUMLINES, LINEWORDS);

   logic [TAGB-1:0] pc_tag;
   logic [INDB-1:0] pc_index;
   logic [OFFB-1:0] pc_word;
   logic            unused_pc_bits;

   assign pc_tag         = pc[31 -: TAGB];
   assign pc_index       = pc[2+OFFB +: INDB];
   assign pc_word        = pc[2 +: OFFB];
   assign unused_pc_bits = ^pc[1:0];

   cache_state_e    state_q, state_d;
   logic [TAGB-1:0] filltag_q, filltag_d;
   logic [INDB-1:0] fillindex_q, fillindex_d;
   logic [OFFB-1:0] wordcnt_q, wordcnt_d;

   logic            rd_valid;
   logic [TAGB-1:0] rd_tag;
   logic [31:0]     rd_data;
   logic            hit;
   logic            wr_en, set_valid, clr_valid, flash_clr;

   icache_array #(
      .NUMLINES  (NUMLINES),
      .LINEWORDS (LINEWORDS)
   ) u_array (
      .ph1         (ph1),
      .reset       (reset),
      .rd_index_i  (pc_index),
      .rd_word_i   (pc_word),
      .rd_valid_o  (rd_valid),
      .rd_tag_o    (rd_tag),
      .rd_data_o   (rd_data),
      .wr_en_i     (wr_en),
      .wr_index_i  (fillindex_q),
      .wr_word_i   (wordcnt_q),
      .wr_data_i   (memdata),
      .wr_tag_i    (filltag_q),
      .set_valid_i (set_valid),
      .clr_index_i (pc_index),
      .clr_valid_i (clr_valid),
      .flash_clr_i (flash_clr)
   );

   assign hit        = rd_valid && (rd_tag == pc_tag);
   assign instrack   = (state_q == IDLE) && !reset && hit;
   assign instr      = rd_data;
   assign memrequest = (state_q == FILL);
   assign memadr     = {filltag_q, fillindex_q, wordcnt_q, 2'b00};

   // NOTE: every signal written here gets a default first, so no path through
   // the branches can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      filltag_d   = filltag_q;
      fillindex_d = fillindex_q;
      wordcnt_d   = wordcnt_q;
      wr_en       = 1'b0;
      set_valid   = 1'b0;
      clr_valid   = 1'b0;
      flash_clr   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (invalidate) begin
               flash_clr = 1'b1;
            end else if (!hit) begin
               filltag_d   = pc_tag;
               fillindex_d = pc_index;
               wordcnt_d   = '0;
               // The victim line may still hold an old tag; drop it now so a
               // half-written line can never produce a hit.
               clr_valid   = 1'b1;
               state_d     = FILL;
            end
         end
         FILL: begin
            if (invalidate) begin
               // Abort: a memack arriving in this cycle is discarded.
               flash_clr = 1'b1;
               state_d   = IDLE;
            end else if (memack) begin
               wr_en     = 1'b1;
               wordcnt_d = wordcnt_q + 1'b1;
               if (wordcnt_q == OFFB'(LINEWORDS - 1)) begin
                  set_valid = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         state_q     <= IDLE;
         filltag_q   <= '0;
         fillindex_q <= '0;
         wordcnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         filltag_q   <= filltag_d;
         fillindex_q <= fillindex_d;
         wordcnt_q   <= wordcnt_d;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache at default geometry (64 lines x 4 words).
// Memory returns a fixed address-derived pattern; memack is produced by a
// small responder that acknowledges every ack_every-th requested cycle.
module tb_icache;

   logic        ph1 = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = 32'h0;
   logic        invalidate = 1'b0;
   logic [31:0] instr;
   logic        instrack;
   logic [31:0] memadr;
   logic        memrequest;
   logic [31:0] memdata;
   logic        memack = 1'b0;

   int tests = 0;
   int fails = 0;
   int ack_every = 1;

   icache dut (
      .ph1        (ph1),
      .reset      (reset),
      .pc         (pc),
      .invalidate (invalidate),
      .instr      (instr),
      .instrack   (instrack),
      .memadr     (memadr),
      .memrequest (memrequest),
      .memdata    (memdata),
      .memack     (memack)
   );

   initial forever #5 ph1 = ~ph1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign memdata = mem_word(memadr);

   // Memory responder: acknowledges the ack_every-th cycle of each request.
   initial begin
      int wait_cnt = 0;
      forever begin
         @(posedge ph1);
         #1;
         if (memrequest === 1'b1) begin
            if (wait_cnt >= ack_every - 1) begin
               memack   = 1'b1;
               wait_cnt = 0;
            end else begin
               memack   = 1'b0;
               wait_cnt++;
            end
         end else begin
            memack   = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge ph1);
      #1;
   endtask

   // Runs until instrack rises (returns at that negedge) or the bound expires.
   task automatic wait_hit(input string name, input int bound);
      logic got = 1'b0;
      for (int c = 0; c < bound; c++) begin
         @(negedge ph1);
         if (instrack === 1'b1) begin
            got = 1'b1;
            break;
         end
         next_cycle();
      end
      check({name, "_hit"}, 32'(got), 32'd1);
   endtask

   typedef struct {
      logic [31:0] pc;
      logic        exp_ack;
      logic        exp_req;
      logic [31:0] exp_adr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] p, input logic a, input logic r, input logic [31:0] adr);
      vec_t v;
      v.pc      = p;
      v.exp_ack = a;
      v.exp_req = r;
      v.exp_adr = adr;
      vecs.push_back(v);
   endtask

   // Miss cycle followed by four refill cycles with acks every cycle.
   task automatic add_miss_fill(input logic [31:0] p);
      add(p, 1'b0, 1'b0, 32'h0);
      for (int w = 0; w < 4; w++) add(p, 1'b0, 1'b1, (p & ~32'hF) + 32'(4 * w));
   endtask

   initial begin
      int          miss;
      logic        got;
      logic [31:0] adr_log[6];

      // Cold fill of 0x40, then hit within the line.
      add_miss_fill(32'h40);
      add(32'h40, 1'b1, 1'b0, 32'h0);
      add(32'h4C, 1'b1, 1'b0, 32'h0);
      // Conflict at index 16: 0x100 and 0x500 evict each other.
      add_miss_fill(32'h100);
      add(32'h100, 1'b1, 1'b0, 32'h0);
      add_miss_fill(32'h500);
      add(32'h504, 1'b1, 1'b0, 32'h0);
      add_miss_fill(32'h100);
      add(32'h108, 1'b1, 1'b0, 32'h0);
      add(32'h48, 1'b1, 1'b0, 32'h0);

      // Reset state.
      next_cycle();
      @(negedge ph1);
      check("rst_instrack", 32'(instrack), 32'd0);
      check("rst_memrequest", 32'(memrequest), 32'd0);
      check("rst_memadr", memadr, 32'h0);
      next_cycle();
      reset = 1'b0;

      foreach (vecs[i]) begin
         pc = vecs[i].pc;
         @(negedge ph1);
         check($sformatf("vec%0d_instrack", i), 32'(instrack), 32'(vecs[i].exp_ack));
         check($sformatf("vec%0d_memrequest", i), 32'(memrequest), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req) check($sformatf("vec%0d_memadr", i), memadr, vecs[i].exp_adr);
         if (vecs[i].exp_ack) check($sformatf("vec%0d_instr", i), instr, mem_word(vecs[i].pc & ~32'h3));
         next_cycle();
      end

      // Slow memory: ack every third cycle, 13 cycles without instrack.
      ack_every = 3;
      pc        = 32'h200;
      miss      = 0;
      got       = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge ph1);
         if (c < 6) adr_log[c] = memadr;
         if (instrack === 1'b1) begin
            got = 1'b1;
            break;
         end
         miss++;
         next_cycle();
      end
      check("slow_hit", 32'(got), 32'd1);
      check("slow_miss_cycles", 32'(miss), 32'd13);
      check("slow_adr_c1", adr_log[1], 32'h200);
      check("slow_adr_c2", adr_log[2], 32'h200);
      check("slow_adr_c3", adr_log[3], 32'h200);
      check("slow_adr_c4", adr_log[4], 32'h204);
      check("slow_instr", instr, mem_word(32'h200));
      next_cycle();
      ack_every = 1;

      // invalidate in IDLE, then invalidate during a fill after two acks.
      pc = 32'h40;
      @(negedge ph1);
      check("inv_pre_hit", 32'(instrack), 32'd1);
      next_cycle();
      invalidate = 1'b1;
      next_cycle();
      invalidate = 1'b0;
      @(negedge ph1);
      check("inv_idle_miss", 32'(instrack), 32'd0);
      next_cycle();
      @(negedge ph1);
      check("inv_fill_adr0", memadr, 32'h40);
      next_cycle();
      @(negedge ph1);
      check("inv_fill_adr1", memadr, 32'h44);
      next_cycle();
      invalidate = 1'b1;
      @(negedge ph1);
      check("inv_fill_adr2", memadr, 32'h48);
      next_cycle();
      invalidate = 1'b0;
      @(negedge ph1);
      check("inv_abort_req", 32'(memrequest), 32'd0);
      check("inv_abort_instrack", 32'(instrack), 32'd0);
      next_cycle();
      @(negedge ph1);
      check("inv_restart_req", 32'(memrequest), 32'd1);
      check("inv_restart_adr", memadr, 32'h40);
      wait_hit("inv_refill", 20);
      check("inv_refill_instr", instr, mem_word(32'h40));
      next_cycle();

      // pc moves 0x40 -> 0x80 while 0x40 is filling.
      invalidate = 1'b1;
      next_cycle();
      invalidate = 1'b0;
      next_cycle();
      @(negedge ph1);
      check("pcchg_adr0", memadr, 32'h40);
      next_cycle();
      pc = 32'h80;
      @(negedge ph1);
      check("pcchg_busy_instrack", 32'(instrack), 32'd0);
      check("pcchg_adr1", memadr, 32'h44);
      next_cycle();
      next_cycle();
      @(negedge ph1);
      check("pcchg_adr3", memadr, 32'h4C);
      next_cycle();
      @(negedge ph1);
      check("pcchg_idle_req", 32'(memrequest), 32'd0);
      next_cycle();
      @(negedge ph1);
      check("pcchg_new_adr", memadr, 32'h80);
      wait_hit("pcchg_80", 20);
      check("pcchg_80_instr", instr, mem_word(32'h80));
      next_cycle();
      pc = 32'h40;
      @(negedge ph1);
      check("pcchg_40_hit", 32'(instrack), 32'd1);
      check("pcchg_40_instr", instr, mem_word(32'h40));
      next_cycle();

      // Reset masks a hit and clears all lines.
      reset = 1'b1;
      @(negedge ph1);
      check("rst_masks_hit", 32'(instrack), 32'd0);
      next_cycle();
      reset = 1'b0;
      @(negedge ph1);
      check("rst_all_miss", 32'(instrack), 32'd0);
      check("rst_idle_req", 32'(memrequest), 32'd0);
      next_cycle();
      @(negedge ph1);
      check("rst_refill_adr0", memadr, 32'h40);
      next_cycle();
      next_cycle();

      // Reset mid-fill, then refill of the same line from its base.
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      pc    = 32'h48;
      @(negedge ph1);
      check("rst_fill_req", 32'(memrequest), 32'd0);
      check("rst_fill_instrack", 32'(instrack), 32'd0);
      next_cycle();
      @(negedge ph1);
      check("rst_fill_restart_adr", memadr, 32'h40);
      wait_hit("rst_refill", 20);
      check("rst_refill_instr", instr, mem_word(32'h48));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
